// File: rtl/apb_disp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | apb_disp_pkg: shared types and constants for apb_req_dispatcher    |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
package apb_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef logic [2:0] sel_t;

  localparam logic [3:0] DEF_TAG1 = 4'h8;
  localparam logic [3:0] DEF_TAG2 = 4'h9;
  localparam logic [3:0] DEF_TAG3 = 4'hA;

  localparam int CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/apb_addr_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | apb_addr_decode: address tag to one-hot slave select              |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module apb_addr_decode
  import apb_disp_pkg::*;
#(
  parameter logic [3:0] TAG1 = DEF_TAG1,
  parameter logic [3:0] TAG2 = DEF_TAG2,
  parameter logic [3:0] TAG3 = DEF_TAG3
) (
  input  logic [3:0] tag_i,
  output sel_t       sel_o,
  output logic       hit_o
);

  // Priority chain: equal tags resolve to the lowest slave index.
  always_comb begin
    sel_o = '0;
    if (tag_i == TAG1)      sel_o = 3'b001;
    else if (tag_i == TAG2) sel_o = 3'b010;
    else if (tag_i == TAG3) sel_o = 3'b100;
    hit_o = |sel_o;
  end

endmodule
`default_nettype wire

// File: rtl/apb_req_dispatcher.sv
`default_nettype none
// +------------------------------------------------------------------+
// | apb_req_dispatcher: three-slave setup/access bus initiator        |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module apb_req_dispatcher
  import apb_disp_pkg::*;
#(
  parameter logic [3:0] TAG1    = DEF_TAG1,
  parameter logic [3:0] TAG2    = DEF_TAG2,
  parameter logic [3:0] TAG3    = DEF_TAG3,
  parameter int         TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [2:0]  psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata1,
  input  logic [31:0] prdata2,
  input  logic [31:0] prdata3,
  input  logic        pready1,
  input  logic        pready2,
  input  logic        pready3
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  sel_t             psel_q;
  logic             penable_q;
  logic             pwrite_q;
  logic [31:0]      paddr_q;
  logic [31:0]      pwdata_q;
  logic             rsp_valid_q;
  logic [31:0]      rsp_rdata_q;
  logic             rsp_err_q;

  sel_t             dec_sel;
  logic             dec_hit;
  logic             sel_ready;
  logic [31:0]      sel_rdata;

  apb_addr_decode #(
    .TAG1 (TAG1),
    .TAG2 (TAG2),
    .TAG3 (TAG3)
  ) u_decode (
    .tag_i (req_addr[31:28]),
    .sel_o (dec_sel),
    .hit_o (dec_hit)
  );

  // Only the registered select steers the mux, so unselected slaves cannot leak X.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    case (psel_q)
      3'b001:  begin sel_ready = pready1; sel_rdata = prdata1; end
      3'b010:  begin sel_ready = pready2; sel_rdata = prdata2; end
      3'b100:  begin sel_ready = pready3; sel_rdata = prdata3; end
      default: begin sel_ready = 1'b0;    sel_rdata = '0;      end
    endcase
  end

  assign cnt_d     = cnt_q + 1'b1;
  assign req_ready = nRST && (state_q == ST_IDLE);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rsp_valid_q <= 1'b0;
          if (req_valid) begin
            paddr_q  <= req_addr;
            pwrite_q <= req_write;
            pwdata_q <= req_wdata;
            if (dec_hit) begin
              psel_q  <= dec_sel;
              state_q <= ST_SETUP;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
              state_q     <= ST_RESP;
            end
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // A ready on the expiring cycle still completes normally.
          if (sel_ready) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= pwrite_q ? 32'h0 : sel_rdata;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            state_q     <= ST_RESP;
          end else if (cnt_q == CNT_LAST) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_RESP: begin
          rsp_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_req_dispatcher.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_apb_req_dispatcher: directed self-checking bench               |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module tb_apb_req_dispatcher;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata1, prdata2, prdata3;
  logic        pready1, pready2, pready3;

  int n_pass  = 0;
  int n_total = 0;
  int acc;

  always #5 CLK = ~CLK;

  apb_req_dispatcher dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata1   (prdata1),
    .prdata2   (prdata2),
    .prdata3   (prdata3),
    .pready1   (pready1),
    .pready2   (pready2),
    .pready3   (pready3)
  );

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    tick();
    req_valid = 1'b0;
    req_write = ~wr;
    req_addr  = 32'h5555_AAAA;
    req_wdata = 32'hFFFF_0000;
  endtask

  initial begin
    nRST = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0;
    prdata1 = '0; prdata2 = '0; prdata3 = '0;
    pready1 = 1'b0; pready2 = 1'b0; pready3 = 1'b0;
    tick(); tick();

    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_psel",      {29'b0, psel}, 32'd0);
    chk("rst_penable",   {31'b0, penable}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_paddr",     paddr, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);

    nRST = 1'b1;
    tick();
    chk("idle_req_ready", {31'b0, req_ready}, 32'd1);

    // Read slave 2, zero wait states
    prdata2 = 32'hDEAD_BEEF; pready2 = 1'b1;
    issue(1'b0, 32'h9000_0010, 32'h0);
    chk("rd2_setup_psel",    {29'b0, psel}, 32'b010);
    chk("rd2_setup_penable", {31'b0, penable}, 32'd0);
    chk("rd2_setup_ready",   {31'b0, req_ready}, 32'd0);
    chk("rd2_paddr",         paddr, 32'h9000_0010);
    tick();
    chk("rd2_access_penable", {31'b0, penable}, 32'd1);
    chk("rd2_access_psel",    {29'b0, psel}, 32'b010);
    chk("rd2_access_rspv",    {31'b0, rsp_valid}, 32'd0);
    tick();
    chk("rd2_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("rd2_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("rd2_rsp_err",   {31'b0, rsp_err}, 32'd0);
    chk("rd2_rsp_psel",  {29'b0, psel}, 32'd0);
    pready2 = 1'b0;
    tick();
    chk("rd2_idle_rspv",  {31'b0, rsp_valid}, 32'd0);
    chk("rd2_idle_ready", {31'b0, req_ready}, 32'd1);
    chk("rd2_rdata_hold", rsp_rdata, 32'hDEAD_BEEF);

    // Write slave 1, three wait states
    issue(1'b1, 32'h8000_0004, 32'h1234_5678);
    chk("wr1_psel",   {29'b0, psel}, 32'b001);
    chk("wr1_pwrite", {31'b0, pwrite}, 32'd1);
    chk("wr1_pwdata", pwdata, 32'h1234_5678);
    tick(); tick(); tick(); tick();
    chk("wr1_wait_penable", {31'b0, penable}, 32'd1);
    chk("wr1_wait_rspv",    {31'b0, rsp_valid}, 32'd0);
    pready1 = 1'b1;
    tick();
    chk("wr1_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("wr1_rsp_rdata", rsp_rdata, 32'd0);
    chk("wr1_rsp_err",   {31'b0, rsp_err}, 32'd0);
    pready1 = 1'b0;
    tick();

    // Decode miss
    issue(1'b0, 32'h1000_0000, 32'h0);
    chk("miss_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("miss_rsp_err",   {31'b0, rsp_err}, 32'd1);
    chk("miss_rsp_rdata", rsp_rdata, 32'd0);
    chk("miss_psel",      {29'b0, psel}, 32'd0);
    tick();
    chk("miss_idle_ready", {31'b0, req_ready}, 32'd1);
    chk("miss_idle_rspv",  {31'b0, rsp_valid}, 32'd0);

    // Timeout on slave 3: sixteen ACCESS cycles then error
    prdata3 = 32'h3333_3333;
    issue(1'b0, 32'hA000_0000, 32'h0);
    chk("to_psel", {29'b0, psel}, 32'b100);
    tick();
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      if (penable === 1'b1 && rsp_valid === 1'b0) acc++;
      tick();
    end
    chk("to_access_cycles", acc, 32'd16);
    chk("to_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("to_rsp_err",   {31'b0, rsp_err}, 32'd1);
    chk("to_rsp_rdata", rsp_rdata, 32'd0);
    tick();
    chk("to_idle_ready", {31'b0, req_ready}, 32'd1);

    // Ready arrives on the expiring cycle: no error
    issue(1'b0, 32'hA000_0040, 32'h0);
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("edge_still_access", {31'b0, penable}, 32'd1);
    pready3 = 1'b1;
    tick();
    chk("edge_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("edge_rsp_err",   {31'b0, rsp_err}, 32'd0);
    chk("edge_rsp_rdata", rsp_rdata, 32'h3333_3333);
    pready3 = 1'b0;
    tick();

    // Slave-1 read with noisy unselected slaves
    prdata1 = 32'hCAFE_F00D; pready1 = 1'b0;
    pready2 = 1'b1; prdata2 = 'x; pready3 = 1'bz; prdata3 = 'z;
    issue(1'b0, 32'h8000_0020, 32'h0);
    tick();
    chk("iso_access_penable", {31'b0, penable}, 32'd1);
    chk("iso_access_rspv",    {31'b0, rsp_valid}, 32'd0);
    pready1 = 1'b1;
    tick();
    chk("iso_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("iso_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
    chk("iso_rsp_err",   {31'b0, rsp_err}, 32'd0);
    pready1 = 1'b0;
    tick();

    // Reset asserted during ACCESS abandons the transfer
    issue(1'b0, 32'h8000_0030, 32'h0);
    tick();
    chk("rst_mid_access", {31'b0, penable}, 32'd1);
    nRST = 1'b0;
    chk("rst_mid_ready_low", {31'b0, req_ready}, 32'd0);
    tick();
    chk("rst_mid_psel",    {29'b0, psel}, 32'd0);
    chk("rst_mid_penable", {31'b0, penable}, 32'd0);
    chk("rst_mid_rspv",    {31'b0, rsp_valid}, 32'd0);
    nRST = 1'b1;
    pready1 = 1'b1;
    tick();
    chk("rst_rel_ready", {31'b0, req_ready}, 32'd1);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid !== 1'b0) acc++;
      tick();
    end
    chk("rst_no_rsp", acc, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
